hazard_controller: RTL

- Central hazard unit. Produces the stall/flush pair consumed by every pipeline register: pc, i2d, d2e, e2m, m2w.
- Resolves four hazard causes: i-cache miss, load-use, branch mispredict and d-cache miss.
- Owns the sequential state needed so that a branch redirect arriving while the PC is stalled is never lost.
- Also sequences a post-reset flush window and keeps saturating per-cause performance counters.

---
 rtl/hazard_controller_pkg.sv | 29 ++
 rtl/hazard_controller_if.sv | 17 +
 rtl/hazard_controller_sat_counter.sv | 30 +++
 rtl/hazard_controller.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/hazard_controller_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hazard_controller_pkg                                           |
// | Purpose  : Shared types and constants for the pipeline hazard unit.        |
// |            hazard_cause_t names the cause that wins the priority encode.   |
// | Contents : hazard_cause_t, RESET_FLUSH_CYCLES_DEFAULT, stage indices        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package hazard_controller_pkg;

   typedef enum logic [2:0] {
      HC_NONE = 3'd0,
      HC_IC   = 3'd1,
      HC_DS   = 3'd2,
      HC_BR   = 3'd3,
      HC_DC   = 3'd4
   } hazard_cause_t;

   localparam int RESET_FLUSH_CYCLES_DEFAULT = 2;

   // Bit positions of each pipeline register in the internal stall/flush vectors
   localparam int ST_PC  = 0;
   localparam int ST_I2D = 1;
   localparam int ST_D2E = 2;
   localparam int ST_E2M = 3;
   localparam int ST_M2W = 4;

endpackage
`default_nettype wire

// File: rtl/hazard_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : hazard_controller_if                                           |
// | Purpose   : Hold/bubble control for one pipeline register.                 |
// | Ports     : stall - register keeps its current contents                    |
// |             flush - register loads a bubble                                |
// |             master modport drives, slave modport (stage register) reads    |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface hazard_controller_if;
   logic stall;
   logic flush;

   modport master (output stall, output flush);
   modport slave  (input  stall, input  flush);
endinterface
`default_nettype wire

// File: rtl/hazard_controller_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hazard_controller_sat_counter                                   |
// | Purpose  : Saturating event counter; sticks at all-ones, never wraps.      |
// | Ports    : clk, rst_n (async active-low), inc (count this cycle),          |
// |            clr (zero next edge, beats inc), value (current count)          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module hazard_controller_sat_counter #(
   parameter int CNT_W = 32
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             inc,
   input  wire logic             clr,
   output logic      [CNT_W-1:0] value
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (inc && (value != '1)) begin
         value <= value + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : hazard_controller                                               |
// | Purpose  : Central hazard unit. Priority-encodes i-cache miss, load-use,   |
// |            branch mispredict and d-cache miss into stall/flush for every   |
// |            pipeline register, keeps a redirect that arrives while the PC   |
// |            is stalled, sequences a post-reset flush window and counts      |
// |            each hazard cause.                                              |
// | Ports    : clk, rst_n (async active-low)                                   |
// |            ic_miss, ds_miss, ex_mispredict, ex_redirect_pc, dc_miss        |
// |            ctr_clear                                                       |
// |            pc/i2d/d2e/e2m/m2w_ctl : stall/flush interface per stage        |
// |            pc_redirect_valid, pc_redirect : PC load request                |
// |            cnt_ic, cnt_ds, cnt_dc, cnt_br : saturating cause counters      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module hazard_controller
   import hazard_controller_pkg::*;
#(
   parameter int RESET_FLUSH_CYCLES = RESET_FLUSH_CYCLES_DEFAULT,
   parameter int CNT_W              = 32,
   parameter int ADDR_W             = 32
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   input  wire logic              ic_miss,
   input  wire logic              ds_miss,
   input  wire logic              ex_mispredict,
   input  wire logic [ADDR_W-1:0] ex_redirect_pc,
   input  wire logic              dc_miss,
   input  wire logic              ctr_clear,
   hazard_controller_if.master    pc_ctl,
   hazard_controller_if.master    i2d_ctl,
   hazard_controller_if.master    d2e_ctl,
   hazard_controller_if.master    e2m_ctl,
   hazard_controller_if.master    m2w_ctl,
   output logic                   pc_redirect_valid,
   output logic      [ADDR_W-1:0] pc_redirect,
   output logic      [CNT_W-1:0]  cnt_ic,
   output logic      [CNT_W-1:0]  cnt_ds,
   output logic      [CNT_W-1:0]  cnt_dc,
   output logic      [CNT_W-1:0]  cnt_br
);

   localparam int INIT_W = (RESET_FLUSH_CYCLES > 0) ? $clog2(RESET_FLUSH_CYCLES + 1) : 1;

   logic [INIT_W-1:0] init_cnt;
   logic              redir_pending;
   logic [ADDR_W-1:0] redir_target;
   logic              startup;
   logic              redirect;
   hazard_cause_t     cause;
   logic [4:0]        stall;
   logic [4:0]        flush;

   // Reset is folded in combinationally so the flush pattern is present while
   // rst_n is low, even for a zero-length startup window.
   assign startup  = !rst_n || (init_cnt != '0);
   assign redirect = ex_mispredict || redir_pending;

   // Priority: dc_miss > redirect > ds_miss > ic_miss
   always_comb begin
      cause = HC_NONE;
      if (dc_miss)       cause = HC_DC;
      else if (redirect) cause = HC_BR;
      else if (ds_miss)  cause = HC_DS;
      else if (ic_miss)  cause = HC_IC;
   end

   always_comb begin
      stall             = '0;
      flush             = '0;
      pc_redirect_valid = 1'b0;
      pc_redirect       = '0;
      if (startup) begin
         // Whole pipe is bubbled while the PC holds its reset vector.
         stall[ST_PC] = 1'b1;
         flush        = '1;
      end else begin
         unique case (cause)
            HC_DC: begin
               // Everything up to MEM holds; EX re-presents any mispredict.
               stall[ST_PC]  = 1'b1;
               stall[ST_I2D] = 1'b1;
               stall[ST_D2E] = 1'b1;
               stall[ST_E2M] = 1'b1;
               flush[ST_M2W] = 1'b1;
            end
            HC_BR: begin
               flush[ST_I2D] = 1'b1;
               flush[ST_D2E] = 1'b1;
               if (ic_miss) begin
                  // Fetch is busy; the target waits in redir_target.
                  stall[ST_PC] = 1'b1;
               end else begin
                  pc_redirect_valid = 1'b1;
                  pc_redirect       = redir_pending ? redir_target : ex_redirect_pc;
               end
            end
            HC_DS: begin
               stall[ST_PC]  = 1'b1;
               stall[ST_I2D] = 1'b1;
               flush[ST_D2E] = 1'b1;
            end
            HC_IC: begin
               stall[ST_PC]  = 1'b1;
               flush[ST_I2D] = 1'b1;
            end
            default: ;
         endcase
         // A held register must never also be bubbled.
         flush = flush & ~stall;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_cnt      <= INIT_W'(RESET_FLUSH_CYCLES);
         redir_pending <= 1'b0;
         redir_target  <= '0;
      end else if (init_cnt != '0) begin
         init_cnt <= init_cnt - INIT_W'(1);
      end else if (!dc_miss && redirect) begin
         if (!ic_miss) begin
            redir_pending <= 1'b0;
         end else if (ex_mispredict) begin
            // A later mispredict overwrites; d2e flushing makes that unreachable.
            redir_pending <= 1'b1;
            redir_target  <= ex_redirect_pc;
         end
      end
   end

   assign pc_ctl.stall  = stall[ST_PC];
   assign pc_ctl.flush  = flush[ST_PC];
   assign i2d_ctl.stall = stall[ST_I2D];
   assign i2d_ctl.flush = flush[ST_I2D];
   assign d2e_ctl.stall = stall[ST_D2E];
   assign d2e_ctl.flush = flush[ST_D2E];
   assign e2m_ctl.stall = stall[ST_E2M];
   assign e2m_ctl.flush = flush[ST_E2M];
   assign m2w_ctl.stall = stall[ST_M2W];
   assign m2w_ctl.flush = flush[ST_M2W];

   logic inc_ic, inc_ds, inc_dc, inc_br;
   assign inc_ic = !startup && ic_miss;
   assign inc_ds = !startup && (cause == HC_DS);
   assign inc_dc = !startup && dc_miss;
   assign inc_br = !startup && ex_mispredict && !dc_miss;

   hazard_controller_sat_counter #(.CNT_W(CNT_W)) u_cnt_ic (
      .clk(clk), .rst_n(rst_n), .inc(inc_ic), .clr(ctr_clear), .value(cnt_ic));
   hazard_controller_sat_counter #(.CNT_W(CNT_W)) u_cnt_ds (
      .clk(clk), .rst_n(rst_n), .inc(inc_ds), .clr(ctr_clear), .value(cnt_ds));
   hazard_controller_sat_counter #(.CNT_W(CNT_W)) u_cnt_dc (
      .clk(clk), .rst_n(rst_n), .inc(inc_dc), .clr(ctr_clear), .value(cnt_dc));
   hazard_controller_sat_counter #(.CNT_W(CNT_W)) u_cnt_br (
      .clk(clk), .rst_n(rst_n), .inc(inc_br), .clr(ctr_clear), .value(cnt_br));

endmodule
`default_nettype wire
